cbd_poly_buf: RTL
=================

CBD_POLY_BUF -- requirements
Module: cbd_poly_buf

Interface
REQ-001 SHALL have parameter KYBER_Q, default 3329, modulus used for normalization.
REQ-002 SHALL have parameter NPAIR, default 128, coefficient pairs per polynomial (256 coefficients).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port set  input  1  global enable; all state frozen while low.
REQ-006 SHALL have port din_1  input  16  signed coefficient 2k from upstream CBD sampler.
REQ-007 SHALL have port din_2  input  16  signed coefficient 2k+1 from upstream CBD sampler.
REQ-008 SHALL have port din_valid  input  1  din_1/din_2 carry a valid pair this cycle.
REQ-009 SHALL have port ok_in  output  1  block accepts pairs (FILL state).
REQ-010 SHALL have port full  output  1  all NPAIR pairs stored; polynomial readable (FULL state).
REQ-011 SHALL have port rd_req  input  1  read request in FULL.
REQ-012 SHALL have port rd_addr  input  7  pair index to read.
REQ-013 SHALL have port dout_1  output  12  normalized coefficient 2k.
REQ-014 SHALL have port dout_2  output  12  normalized coefficient 2k+1.
REQ-015 SHALL have port dout_valid  output  1  dout_1/dout_2 valid this cycle.
REQ-016 SHALL have port release  input  1  consumer done; return to FILL.
REQ-017 SHALL have port range_err  output  1  sticky out-of-range input flag.

Function
REQ-018 SHALL implement two states, FILL and FULL; ok_in = (state==FILL), full = (state==FULL).
REQ-019 In FILL, set && din_valid SHALL write both normalized coefficients as one pair at index wr_cnt, then increment wr_cnt (7-bit).
REQ-020 Normalization SHALL be: v<0 -> (v + KYBER_Q) truncated to 12 bits; v>=0 -> v truncated to 12 bits; one conditional add, no further reduction.
REQ-021 Acceptance of pair NPAIR-1 SHALL move the state to FULL on the next edge; wr_cnt SHALL wrap to 0.
REQ-022 din_valid in FULL SHALL be ignored; no write, no counter change.
REQ-023 In FULL, set && rd_req SHALL sample rd_addr; dout_1/dout_2 SHALL present that pair with dout_valid=1 exactly one cycle later.
REQ-024 dout_valid SHALL be 0 in any cycle not following an accepted read; dout_1/dout_2 SHALL hold their last value otherwise.
REQ-025 rd_req in FILL SHALL be ignored (dout_valid stays 0).
REQ-026 In FULL, set && release SHALL return to FILL next edge; a read accepted in the same cycle SHALL still complete with dout_valid next cycle.
REQ-027 release in FILL SHALL be ignored.
REQ-028 Stored data SHALL be retained after release until overwritten by new fills.
REQ-029 With set low, no input SHALL be accepted and all registers SHALL hold.

Reset
REQ-030 Reset SHALL force FILL, wr_cnt=0, ok_in=1, full=0, dout_valid=0, dout_1=0, dout_2=0, range_err=0.
REQ-031 Reset mid-fill or mid-read SHALL discard progress; next fill SHALL restart at pair 0; RAM contents need not be cleared.

Configuration
REQ-032 With macro CBD_POLY_RANGE_CHECK_EN defined, any accepted coefficient outside [-2,2] SHALL set range_err, held until reset; data SHALL still be stored per REQ-020.
REQ-033 Without CBD_POLY_RANGE_CHECK_EN, range_err SHALL be tied to 0 and no check logic SHALL exist.

Verification
REQ-034 Fill 128 pairs (din_1=-2, din_2=2) -> full=1 after pair 128, ok_in=0; read pair 0 -> next cycle dout_1=3327, dout_2=2, dout_valid=1.
REQ-035 Fill pair k with (-1, k mod 3 - 1), read all 128 back-to-back -> one pair per cycle, dout_1=3328, dout_2 matches normalization, no gaps.
REQ-036 din_valid held high for 140 cycles from reset -> exactly 128 writes; extra 12 pairs do not alter RAM; full=1.
REQ-037 rd_req and release same cycle in FULL -> dout_valid=1 next cycle with correct data, ok_in=1 same cycle.
REQ-038 Reset asserted after 50 pairs -> ok_in=1, full=0; refill of 128 pairs required before full=1.
REQ-039 With CBD_POLY_RANGE_CHECK_EN, inject din_1=3 -> range_err=1 next cycle, stays 1 through release; without macro -> range_err=0.

Source files
------------

// File: rtl/cbd_poly_buf.sv
// ---------------------------------------------------------------------------
// cbd_poly_buf
//   Ping-pong-free polynomial buffer between a CBD sampler and its consumer.
//   The sampler delivers coefficient pairs (2k, 2k+1) as signed 16-bit values.
//   Each value is normalized into [0, 4095] with one conditional add of
//   KYBER_Q and stored as one 24-bit word. Once NPAIR pairs are stored the
//   block turns FULL and serves random-access pair reads until the consumer
//   releases it, which re-opens the block for the next fill.
//
//   Build option: define CBD_POLY_RANGE_CHECK_EN to add a sticky flag that
//   records any accepted coefficient outside [-2, 2]. Without it range_err
//   is tied low and no check logic exists.
//
// Handshake: a pair is accepted on a rising edge where set && din_valid &&
//   ok_in; a read is accepted on a rising edge where set && rd_req && full,
//   and its data appears with dout_valid=1 in the following cycle. There is
//   no back-pressure on the read side. With set low nothing is accepted and
//   every register holds.
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   asynchronous, active-high reset
//   set         in   global enable; all state frozen while low
//   din_1/din_2 in   signed coefficients 2k / 2k+1
//   din_valid   in   din_1/din_2 carry a pair this cycle
//   ok_in       out  block accepts pairs (FILL)
//   full        out  polynomial complete and readable (FULL)
//   rd_req      in   read request (FULL only)
//   rd_addr     in   pair index to read
//   dout_1/2    out  normalized coefficients of the read pair
//   dout_valid  out  dout_1/dout_2 carry a fresh read this cycle
//   release_i   in   consumer done, return to FILL ("release" is a reserved
//                    word in SystemVerilog, hence the suffix)
//   range_err   out  sticky out-of-range input flag
//   dbg_state   out  current FSM state (0 = FILL, 1 = FULL)
// ---------------------------------------------------------------------------
module cbd_poly_buf #(
  parameter int KYBER_Q = 3329,
  parameter int NPAIR   = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        set,
  input  logic [15:0] din_1,
  input  logic [15:0] din_2,
  input  logic        din_valid,
  output logic        ok_in,
  output logic        full,
  input  logic        rd_req,
  input  logic [6:0]  rd_addr,
  output logic [11:0] dout_1,
  output logic [11:0] dout_2,
  output logic        dout_valid,
  input  logic        release_i,
  output logic        range_err,
  output logic        dbg_state
);

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  wr_cnt_q, wr_cnt_d;
  logic        wr_en;
  logic        rd_en;
  logic        wr_last;
  logic [11:0] dout_1_q, dout_2_q;
  logic        dout_valid_q;

  // Pair storage; no reset so it maps onto RAM.
  logic [23:0] mem [NPAIR];

  // Negative inputs get one add of KYBER_Q; the result is simply truncated,
  // no further modular reduction is performed.
  function automatic logic [11:0] norm(input logic [15:0] v);
    norm = v[15] ? 12'(v + 16'(KYBER_Q)) : v[11:0];
  endfunction

  assign wr_last  = (wr_cnt_q == 7'(NPAIR - 1));
  assign wr_cnt_d = wr_last ? 7'd0 : wr_cnt_q + 7'd1;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_FILL;
    else       state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FILL: if (wr_en && wr_last)  state_d = ST_FULL;
      ST_FULL: if (set && release_i)  state_d = ST_FILL;
      default:                        state_d = ST_FILL;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    ok_in     = (state_q == ST_FILL);
    full      = (state_q == ST_FULL);
    dbg_state = state_q;
    wr_en     = set && din_valid && (state_q == ST_FILL);
    rd_en     = set && rd_req && (state_q == ST_FULL);
  end

  // ---------------- write side ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      wr_cnt_q <= 7'd0;
    else if (wr_en) wr_cnt_q <= wr_cnt_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_cnt_q] <= {norm(din_1), norm(din_2)};
  end

  // ---------------- read side ----------------
  // A read accepted together with release still completes: rd_en is
  // decided from the current state, the data path does not look at release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout_valid_q <= 1'b0;
      dout_1_q     <= 12'd0;
      dout_2_q     <= 12'd0;
    end else if (set) begin
      dout_valid_q <= rd_en;
      if (rd_en) {dout_1_q, dout_2_q} <= mem[rd_addr];
    end
  end

  assign dout_1     = dout_1_q;
  assign dout_2     = dout_2_q;
  assign dout_valid = dout_valid_q;

  // ---------------- optional range flag ----------------
`ifdef CBD_POLY_RANGE_CHECK_EN
  logic range_err_q;

  function automatic logic out_of_range(input logic [15:0] v);
    out_of_range = ($signed(v) < -16'sd2) || ($signed(v) > 16'sd2);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      range_err_q <= 1'b0;
    else if (wr_en && (out_of_range(din_1) || out_of_range(din_2)))
      range_err_q <= 1'b1;
  end

  assign range_err = range_err_q;
`else
  assign range_err = 1'b0;
`endif

endmodule
